// File: rtl/dmem_ws.sv
// Wait-state data memory with byte-lane writes, programmable latency and a Valid/Busy handshake.
// Optional wrapping read bursts for cache line fills when DMEM_BURST_EN is defined.
module dmem_ws #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 65536,
    parameter int RD_LAT    = 2,
    parameter int WR_LAT    = 1,
    parameter int BURST_LEN = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                HSEL,
    input  logic                re,
    input  logic                we,
    input  logic [ADDR_W-1:0]   a,
    input  logic [DATA_W-1:0]   wd,
    input  logic [DATA_W/8-1:0] be,
    input  logic                burst,
    output logic [DATA_W-1:0]   rd,
    output logic                Valid,
    output logic                Busy
);
    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam int NBE    = DATA_W / 8;
    localparam int MAXLAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W  = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_XFER
    } state_t;

    state_t state, state_nx;

    logic [DATA_W-1:0] mem [MEM_WORDS];

    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wd_q;
    logic [NBE-1:0]    be_q;
    logic              wr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  rd_idx;
    logic              more_beats;
    logic              accept;
    logic              cnt_done;
    logic              load_rd;
    logic              commit;
    logic              unused;

    assign accept   = (state == S_IDLE) && HSEL && (re || we);
    assign cnt_done = (state == S_WAIT) && (cnt_q == '0);
    assign commit   = cnt_done && wr_q;
    assign load_rd  = !wr_q && (cnt_done || ((state == S_XFER) && more_beats));

`ifdef DMEM_BURST_EN
    localparam int BEAT_W = $clog2(BURST_LEN) + 1;
    localparam logic [IDX_W-1:0] LINE_MASK = IDX_W'(BURST_LEN - 1);

    logic              burst_q;
    logic [BEAT_W-1:0] beat_q;

    // beat_q counts beats already loaded into rd; offset wraps inside the aligned line
    assign rd_idx     = (idx_q & ~LINE_MASK) | ((idx_q + IDX_W'(beat_q)) & LINE_MASK);
    assign more_beats = burst_q && (beat_q != BEAT_W'(BURST_LEN));

    always_ff @(posedge clk) begin
        if (reset) begin
            burst_q <= 1'b0;
            beat_q  <= '0;
        end else begin
            if (accept) begin
                burst_q <= burst && !we;
                beat_q  <= '0;
            end else if (load_rd) begin
                beat_q  <= beat_q + 1'b1;
            end
        end
    end

    assign unused = ^{a[ADDR_W-1:IDX_W+2], a[1:0]};
`else
    localparam int unused_burst_len = BURST_LEN;

    assign rd_idx     = idx_q;
    assign more_beats = 1'b0;
    assign unused     = ^{a[ADDR_W-1:IDX_W+2], a[1:0], burst};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = S_WAIT;
            S_WAIT: if (cnt_q == '0) state_nx = S_XFER;
            S_XFER: if (!more_beats) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= '0;
            wd_q  <= '0;
            be_q  <= '0;
            wr_q  <= 1'b0;
            cnt_q <= '0;
            rd    <= '0;
        end else begin
            if (accept) begin
                idx_q <= a[IDX_W+1:2];
                wd_q  <= wd;
                be_q  <= be;
                wr_q  <= we;
                cnt_q <= we ? CNT_W'(WR_LAT - 1) : CNT_W'(RD_LAT - 1);
            end else if ((state == S_WAIT) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (load_rd) begin
                rd <= mem[rd_idx];
            end
        end
    end

    // RAM is never cleared; reset on the commit edge suppresses the write
    always_ff @(posedge clk) begin
        if (!reset && commit) begin
            for (int unsigned i = 0; i < NBE; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wd_q[8*i +: 8];
                end
            end
        end
    end

    assign Valid = (state == S_XFER);
    assign Busy  = (state != S_IDLE);

endmodule

// File: tb/tb_dmem_ws.sv
// Randomized self-checking bench for dmem_ws against a word-array reference model.
// Burst expectations follow whether DMEM_BURST_EN is defined for the build.
module tb_dmem_ws;
    localparam int RD_LAT = 2;
    localparam int WR_LAT = 3;
    localparam int BL     = 4;
    localparam int WORDS  = 256;
`ifdef DMEM_BURST_EN
    localparam bit BURST_ON = 1'b1;
`else
    localparam bit BURST_ON = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        HSEL;
    logic        re;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        burst;
    logic [31:0] rd;
    logic        Valid;
    logic        Busy;

    dmem_ws #(
        .DATA_W   (32),
        .ADDR_W   (32),
        .MEM_WORDS(WORDS),
        .RD_LAT   (RD_LAT),
        .WR_LAT   (WR_LAT),
        .BURST_LEN(BL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .HSEL (HSEL),
        .re   (re),
        .we   (we),
        .a    (a),
        .wd   (wd),
        .be   (be),
        .burst(burst),
        .rd   (rd),
        .Valid(Valid),
        .Busy (Busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model [WORDS];
    logic [31:0] last_rd_exp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] lanes);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (lanes[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    task automatic idle_inputs();
        HSEL  = 1'b0;
        re    = 1'b0;
        we    = 1'b0;
        a     = $urandom;
        wd    = $urandom;
        be    = 4'($urandom);
        burst = 1'($urandom);
    endtask

    // Issue one request and check latency, beat count, Busy window and data
    task automatic run_op(input logic wr, input logic both, input logic [31:0] addr,
                          input logic [31:0] wdat, input logic [3:0] bev, input logic bst);
        int          idx;
        int          lat;
        int          n;
        int          first;
        int          low;
        logic [31:0] exp_q[$];
        logic [31:0] got_q[$];
        idx   = int'((addr >> 2) % WORDS);
        lat   = wr ? WR_LAT : RD_LAT;
        n     = (!wr && bst && BURST_ON) ? BL : 1;
        first = -1;
        low   = -1;
        if (!wr)
            for (int k = 0; k < n; k++)
                exp_q.push_back(model[(idx & ~(BL - 1)) | ((idx + k) & (BL - 1))]);

        @(posedge clk);
        #1;
        HSEL  = 1'b1;
        re    = !wr || both;
        we    = wr;
        a     = addr;
        wd    = wdat;
        be    = bev;
        burst = bst;
        @(posedge clk);
        #1;
        idle_inputs();
        for (int j = 0; j < 64; j++) begin
            @(negedge clk);
            if (j == 0) check("busy_after_accept", 32'(Busy), 32'd1);
            if (Valid) begin
                if (first < 0) first = j;
                got_q.push_back(rd);
            end
            if (!Busy) begin
                low = j;
                break;
            end
        end
        if (low < 0) check("timeout", 32'd1, 32'd0);
        check("first_valid", 32'(first), 32'(lat));
        check("beats", 32'(got_q.size()), 32'(n));
        check("busy_fall", 32'(low), 32'(lat + n));
        if (wr) begin
            model[idx] = merge(model[idx], wdat, bev);
        end else begin
            for (int k = 0; k < n && k < got_q.size(); k++)
                check("beat_data", got_q[k], exp_q[k]);
            last_rd_exp = exp_q[n - 1];
        end
        check("rd_hold", rd, last_rd_exp);
    endtask

    initial begin
        int nvalid;
        idle_inputs();
        reset       = 1'b1;
        last_rd_exp = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_rd", rd, 32'd0);
        check("reset_valid", 32'(Valid), 32'd0);
        check("reset_busy", 32'(Busy), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int w = 0; w < WORDS; w++)
            run_op(1'b1, 1'b0, 32'(w * 4), $urandom, 4'hF, 1'b0);
        run_op(1'b0, 1'b0, 32'h0000_0024, '0, '0, 1'b0);

        // HSEL low: request must be ignored
        @(posedge clk);
        #1;
        re = 1'b1;
        a  = 32'h40;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("hsel_ignored", 32'(Busy), 32'd0);
        idle_inputs();

        run_op(1'b1, 1'b0, 32'h40, 32'hDEADBEEF, 4'hF, 1'b0);
        run_op(1'b0, 1'b0, 32'h40, '0, '0, 1'b0);
        check("wr_rd_const", rd, 32'hDEADBEEF);
        run_op(1'b1, 1'b0, 32'h40, 32'h00AA0000, 4'b0100, 1'b0);
        run_op(1'b0, 1'b0, 32'h40, '0, '0, 1'b0);
        check("lane_const", rd, 32'hDEAABEEF);
        run_op(1'b1, 1'b0, 32'h40, 32'h11223344, 4'h0, 1'b0);
        run_op(1'b1, 1'b1, 32'h44, 32'hCAFEF00D, 4'hF, 1'b0);
        run_op(1'b0, 1'b0, 32'h40, '0, '0, 1'b0);
        run_op(1'b0, 1'b0, 32'hFFFF_FC44, '0, '0, 1'b0);

        // request while Busy is dropped
        @(posedge clk);
        #1;
        HSEL = 1'b1;
        re   = 1'b1;
        we   = 1'b0;
        a    = 32'h80;
        @(posedge clk);
        #1;
        a = 32'h84;
        @(posedge clk);
        #1;
        idle_inputs();
        nvalid = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (Valid) begin
                nvalid++;
                check("drop_data", rd, model[32'h80 >> 2]);
            end
        end
        check("drop_count", 32'(nvalid), 32'd1);
        last_rd_exp = model[32'h80 >> 2];

        // reset one cycle after accepting a write aborts it
        @(posedge clk);
        #1;
        HSEL = 1'b1;
        we   = 1'b1;
        a    = 32'h10;
        wd   = 32'h1234;
        be   = 4'hF;
        @(posedge clk);
        #1;
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        nvalid = 0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (Valid) nvalid++;
        end
        check("rst_no_valid", 32'(nvalid), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_rd", rd, 32'd0);
        last_rd_exp = '0;
        run_op(1'b0, 1'b0, 32'h10, '0, '0, 1'b0);

        for (int k = 0; k < 4; k++)
            run_op(1'b1, 1'b0, 32'(32'h100 + 4 * k), 32'(k + 1), 4'hF, 1'b0);
        run_op(1'b0, 1'b0, 32'h108, '0, '0, 1'b1);
        check("burst_last", rd, BURST_ON ? 32'd2 : 32'd3);
        run_op(1'b1, 1'b0, 32'h108, 32'hAAAA5555, 4'hF, 1'b1);
        run_op(1'b0, 1'b0, 32'h108, '0, '0, 1'b0);

        for (int i = 0; i < 80; i++)
            run_op(1'($urandom), 1'($urandom), $urandom, $urandom, 4'($urandom), 1'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
